// File: rtl/sar_ctrl.sv
// Successive-approximation controller: drives MSB-first trial codes to a DAC,
// strobes the comparator once per bit and assembles the NBIT result.
module sar_ctrl #(
  parameter int NBIT   = 8,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cmp_out,
  output logic [NBIT-1:0] dac_code,
  output logic            cmp_trig,
  output logic            busy,
  output logic            done,
  output logic [NBIT-1:0] result
);

  localparam int PW = $clog2(NBIT);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_TRIG,
    S_SAMPLE
  } state_t;

  state_t          r_state, w_state;
  logic [NBIT-1:0] r_acc, w_acc;
  logic [PW-1:0]   r_ptr, w_ptr;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [NBIT-1:0] r_dac, w_dac;
  logic [NBIT-1:0] r_result, w_result;
  logic            r_trig, w_trig;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic [NBIT-1:0] w_bit;
  logic [NBIT-1:0] w_bit_dn;
  logic [NBIT-1:0] w_resolved;

  // One-hot masks for the bit under test and the next lower bit.
  assign w_bit    = {{(NBIT-1){1'b0}}, 1'b1} << r_ptr;
  assign w_bit_dn = {{(NBIT-1){1'b0}}, 1'b1} << (r_ptr - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_dac    <= '0;
      r_result <= '0;
      r_trig   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_acc    <= w_acc;
      r_ptr    <= w_ptr;
      r_cnt    <= w_cnt;
      r_dac    <= w_dac;
      r_result <= w_result;
      r_trig   <= w_trig;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_acc      = r_acc;
    w_ptr      = r_ptr;
    w_cnt      = r_cnt;
    w_dac      = r_dac;
    w_result   = r_result;
    w_trig     = 1'b0;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_resolved = r_acc;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state = S_SETTLE;
          w_acc   = '0;
          w_ptr   = PW'(NBIT - 1);
          w_cnt   = '0;
          w_dac   = {1'b1, {(NBIT-1){1'b0}}};
          w_busy  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == CW'(SETTLE - 1)) begin
          w_state = S_TRIG;
          w_trig  = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_TRIG: begin
        w_state = S_SAMPLE;
      end
      S_SAMPLE: begin
        // cmp_out is only looked at here so an undefined level elsewhere stays contained.
        w_resolved = cmp_out ? (r_acc | w_bit) : r_acc;
        w_acc      = w_resolved;
        if (r_ptr != '0) begin
          w_state = S_SETTLE;
          w_ptr   = r_ptr - 1'b1;
          w_cnt   = '0;
          w_dac   = w_resolved | w_bit_dn;
        end else begin
          w_state  = S_IDLE;
          w_result = w_resolved;
          w_dac    = w_resolved;
          w_done   = 1'b1;
          w_busy   = 1'b0;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign dac_code = r_dac;
  assign cmp_trig = r_trig;
  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;

endmodule

// File: tb/tb_sar_ctrl.sv
// Bench for sar_ctrl: three instances (SETTLE 2, 1, 5) with ideal comparators,
// checked cycle by cycle against a binary-search reference of the conversion.
module tb_sar_ctrl;

  localparam int NB = 8;

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 1 : 5;
  endfunction

  logic          clk = 1'b0;
  logic          rst_n_s  [3];
  logic          start_s  [3];
  logic          cmp_s    [3];
  logic [NB-1:0] vin_s    [3];
  logic [NB-1:0] dac_s    [3];
  logic          trig_s   [3];
  logic          busy_s   [3];
  logic          done_s   [3];
  logic [NB-1:0] result_s [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_dut
      sar_ctrl #(.NBIT(NB), .SETTLE(settle_of(gi))) u_dut (
        .clk      (clk),
        .rst_n    (rst_n_s[gi]),
        .start    (start_s[gi]),
        .cmp_out  (cmp_s[gi]),
        .dac_code (dac_s[gi]),
        .cmp_trig (trig_s[gi]),
        .busy     (busy_s[gi]),
        .done     (done_s[gi]),
        .result   (result_s[gi])
      );
      // Ideal comparator: decision latched on the strobe, held afterwards.
      always @(posedge clk) begin
        if (trig_s[gi]) cmp_s[gi] <= (vin_s[gi] >= dac_s[gi]);
      end
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: single start pulse; 1: start held through the whole conversion,
  // dropped in the done cycle; 2: start raised in the done cycle (chain).
  task automatic convert(input int d, input logic [NB-1:0] v, input int mode, input bit chained);
    int s;
    int per;
    int lat;
    int ntrig;
    int bi;
    int vv;
    logic [NB-1:0] tr;
    s     = settle_of(d);
    per   = s + 2;
    lat   = NB * per;
    ntrig = 0;
    vv    = int'(v);
    if (!chained) begin
      @(negedge clk);
      start_s[d] = 1'b1;
    end
    vin_s[d] = v;
    @(posedge clk);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      case (mode)
        1:       start_s[d] = (c < lat);
        2:       start_s[d] = (c == lat);
        default: start_s[d] = 1'b0;
      endcase
      if (c < lat) begin
        bi = c / per;
        tr = NB'(((vv >> (NB - bi)) << (NB - bi)) | (1 << (NB - 1 - bi)));
        chk($sformatf("d%0d v%02h c%0d dac", d, v, c), 32'(dac_s[d]), 32'(tr));
        chk($sformatf("d%0d v%02h c%0d trig", d, v, c), 32'(trig_s[d]), 32'((c % per) == s));
        chk($sformatf("d%0d v%02h c%0d busy", d, v, c), 32'(busy_s[d]), 32'(1));
        chk($sformatf("d%0d v%02h c%0d done", d, v, c), 32'(done_s[d]), 32'(0));
        if (trig_s[d] === 1'b1) ntrig++;
      end else begin
        chk($sformatf("d%0d v%02h done", d, v), 32'(done_s[d]), 32'(1));
        chk($sformatf("d%0d v%02h busy_end", d, v), 32'(busy_s[d]), 32'(0));
        chk($sformatf("d%0d v%02h trig_end", d, v), 32'(trig_s[d]), 32'(0));
        chk($sformatf("d%0d v%02h result", d, v), 32'(result_s[d]), 32'(v));
        chk($sformatf("d%0d v%02h dac_end", d, v), 32'(dac_s[d]), 32'(v));
        chk($sformatf("d%0d v%02h ntrig", d, v), 32'(ntrig), 32'(NB));
      end
    end
    $display("[TB] dut%0d settle=%0d vin=%02h result=%02h trig_pulses=%0d", d, s, v, result_s[d], ntrig);
  endtask

  task automatic idle_check(input int d, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      chk($sformatf("d%0d idle%0d busy", d, c), 32'(busy_s[d]), 32'(0));
      chk($sformatf("d%0d idle%0d done", d, c), 32'(done_s[d]), 32'(0));
      chk($sformatf("d%0d idle%0d trig", d, c), 32'(trig_s[d]), 32'(0));
    end
  endtask

  task automatic abort_bit4(input int d);
    int per;
    per = settle_of(d) + 2;
    vin_s[d] = 8'h3C;
    @(negedge clk);
    start_s[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[d] = 1'b0;
    repeat (4 * per) @(negedge clk);
    rst_n_s[d] = 1'b0;
    #1;
    chk($sformatf("d%0d rst dac", d), 32'(dac_s[d]), 32'(0));
    chk($sformatf("d%0d rst trig", d), 32'(trig_s[d]), 32'(0));
    chk($sformatf("d%0d rst busy", d), 32'(busy_s[d]), 32'(0));
    chk($sformatf("d%0d rst done", d), 32'(done_s[d]), 32'(0));
    chk($sformatf("d%0d rst result", d), 32'(result_s[d]), 32'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("d%0d rst_hold%0d done", d, c), 32'(done_s[d]), 32'(0));
    end
    rst_n_s[d] = 1'b1;
    $display("[TB] dut%0d reset asserted during bit 4, outputs cleared", d);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n_s[i] = 1'b0;
      start_s[i] = 1'b0;
      vin_s[i]   = '0;
      cmp_s[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d reset dac", i), 32'(dac_s[i]), 32'(0));
      chk($sformatf("d%0d reset trig", i), 32'(trig_s[i]), 32'(0));
      chk($sformatf("d%0d reset busy", i), 32'(busy_s[i]), 32'(0));
      chk($sformatf("d%0d reset done", i), 32'(done_s[i]), 32'(0));
      chk($sformatf("d%0d reset result", i), 32'(result_s[i]), 32'(0));
      rst_n_s[i] = 1'b1;
    end

    convert(0, 8'hA5, 0, 1'b0);
    convert(0, 8'h00, 0, 1'b0);
    convert(0, 8'hFF, 0, 1'b0);
    convert(0, NB'($urandom_range(0, 255)), 1, 1'b0);
    idle_check(0, 4);
    convert(0, 8'h3C, 2, 1'b0);
    convert(0, 8'hC3, 0, 1'b1);
    idle_check(0, 2);
    for (int k = 0; k < 10; k++) convert(0, NB'($urandom_range(0, 255)), 0, 1'b0);
    abort_bit4(0);
    convert(0, 8'h5A, 0, 1'b0);

    for (int d = 1; d < 3; d++) begin
      convert(d, 8'h00, 0, 1'b0);
      convert(d, 8'hFF, 0, 1'b0);
      for (int k = 0; k < 3; k++) convert(d, NB'($urandom_range(0, 255)), 0, 1'b0);
      abort_bit4(d);
      convert(d, 8'h5A, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_ctrl.md
# sar_ctrl

Successive-approximation controller driving the reference side of a clocked comparator slice. It generates the trial reference code (through an external DAC onto the comparator's reference input) and the comparator trigger. It then reads back the comparator decision bit and resolves an NBIT result MSB-first. It sits between the digital neuron core, which requests conversions, and the analog slicer/DAC pair, which measures the membrane or input signal.

## Interface
- NBIT, default 8: result and DAC code width; legal range 2..16.
- SETTLE, default 2: cycles the trial code is held before triggering, to cover DAC/reference settling; legal range ≥1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronized externally.
- start  input  1  conversion request, sampled only in IDLE.
- cmp_out  input  1  comparator decision; 1 means input ≥ reference; valid in the SAMPLE state.
- dac_code  output  NBIT  trial or held reference code to the DAC.
- cmp_trig  output  1  comparator latch strobe, high for exactly one cycle per bit.
- busy  output  1  high from start acceptance until the result is produced.
- done  output  1  one-cycle pulse; result is valid from this cycle.
- result  output  NBIT  last completed conversion, held until the next done.

## Operation
- States:
  - IDLE: busy=0, cmp_trig=0, dac_code holds result.
  - SETTLE: dac_code = trial, settle counter running.
  - TRIG: cmp_trig=1.
  - SAMPLE: cmp_out is read.
- IDLE→SETTLE when start=1.
  - Working register acc ← 0.
  - Bit pointer ← NBIT-1.
  - trial = acc | (1<<ptr).
- SETTLE→TRIG after SETTLE cycles in SETTLE. The counter is cleared on every entry.
- TRIG→SAMPLE always, after 1 cycle.
- SAMPLE resolves the current bit:
  - cmp_out=1: acc keeps bit ptr set.
  - cmp_out=0: acc clears bit ptr.
- SAMPLE transitions:
  - ptr>0: ptr decrements, go to SETTLE with the new trial.
  - ptr=0: result ← resolved acc, done=1 for one cycle, busy=0, go to IDLE.
- dac_code is registered. In SETTLE/TRIG/SAMPLE it equals the current trial; in IDLE it equals result.
- start while busy is ignored; there is no queueing.
- The start input and the comparator are independent of any level other than cmp_out. No X on cmp_out may propagate outside the SAMPLE cycle.

## Timing
- Reset values: dac_code=0, cmp_trig=0, busy=0, done=0, result=0, state IDLE.
- Conversion latency:
  - start sampled high at edge k.
  - Per-bit cost is SETTLE+2 edges.
  - done is high in the cycle following edge k+NBIT·(SETTLE+2).
  - Defaults: 32 edges.
- For bit i (0-based from MSB), cmp_trig is high in the cycle after edge k+i·(SETTLE+2)+SETTLE.
- cmp_out is sampled at the edge ending the SAMPLE cycle, i.e. 2 edges after cmp_trig rises. The comparator has one full cycle to resolve.
- dac_code changes only at the edge entering SETTLE and at the edge producing done. It is stable throughout TRIG and SAMPLE.
- Back-to-back: start=1 during the done cycle is accepted. The next conversion's first SETTLE begins the following cycle, with no idle gap beyond that.
- Reset mid-conversion:
  - All outputs return to reset values asynchronously.
  - No done pulse is produced.
  - result is cleared to 0.
- busy rises the cycle after start acceptance and falls in the done cycle.

## Test plan
- Bench comparator model cmp_out = (VIN ≥ dac_code), latched on cmp_trig.
  - NBIT=8, SETTLE=2, VIN=0xA5.
  - Required trial codes: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - Required result: result=0xA5.
  - done exactly 32 cycles after start.
- Extremes: VIN=0x00 → result 0x00. VIN=0xFF → result 0xFF. Exactly 8 cmp_trig pulses each.
- start pulsed every cycle while busy → only one conversion runs; done pulses once; busy is continuous.
- start held high through done → second conversion begins the cycle after done. The two VIN values (0x3C then 0xC3) are reported in order.
- rst_n asserted during bit 4 of a conversion → all outputs 0 immediately, no done. A new start after release converts VIN=0x5A correctly.
- SETTLE=1 and SETTLE=5 sweeps → cmp_trig spacing is 3 and 7 cycles respectively. dac_code is never changed while cmp_trig=1.
